rf_write_scheduler: RTL

Write-port controller and scoreboard for the 32×32 integer register file. It merges two writeback sources onto the single register-file write port. The pipeline WB stage has priority; the long-latency unit (load/mul/div return) is served through a valid/ready handshake with starvation protection. It also tracks destination registers of in-flight long-latency ops and raises a decode-stage stall on RAW/WAW hazards. It sits between the WB stage, the long-latency unit and the register file write port.

---
 rtl/rf_write_scheduler_pkg.sv | 27 ++
 rtl/rf_write_scheduler_scoreboard.sv | 66 ++++++
 rtl/rf_write_scheduler.sv | 129 ++++++++++++
 3 files changed

// File: rtl/rf_write_scheduler_pkg.sv
// Shared types for the register-file write scheduler: widths, write-request
// struct, writeback source tag and starvation FSM states.
package rf_write_scheduler_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int XLEN       = 32;
    localparam int NUM_REGS   = 1 << REG_ADDR_W;

    typedef enum logic {
        SRC_WB = 1'b0,
        SRC_LL = 1'b1
    } src_e;

    typedef enum logic [1:0] {
        NORMAL = 2'd0,
        HOLD   = 2'd1,
        GRANT  = 2'd2
    } state_e;

    typedef struct packed {
        logic                  valid;
        logic [REG_ADDR_W-1:0] addr;
        logic [XLEN-1:0]       data;
        src_e                  src;
    } wr_req_t;

endpackage

// File: rtl/rf_write_scheduler_scoreboard.sv
// Busy-register scoreboard for in-flight long-latency destinations, plus the
// decode-stage hazard compare that produces the stall.
module rf_scoreboard
    import rf_write_scheduler_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  set_valid_i,
    input  logic [REG_ADDR_W-1:0] set_addr_i,
    input  logic                  clr_valid_i,
    input  logic [REG_ADDR_W-1:0] clr_addr_i,
    input  logic                  wr_pending_i,
    input  logic [REG_ADDR_W-1:0] wr_addr_i,
    input  logic [REG_ADDR_W-1:0] rs1_addr_i,
    input  logic [REG_ADDR_W-1:0] rs2_addr_i,
    input  logic [REG_ADDR_W-1:0] rd_addr_i,
    output logic [NUM_REGS-1:0]   busy_vec_o,
    output logic                  id_stall_o
);

    logic [NUM_REGS-1:0]   busy_q;
    logic [NUM_REGS-1:0]   busy_d;
    logic [REG_ADDR_W-1:0] op_addr [3];
    logic [2:0]            op_hit;

    genvar gi;

    // x0 is hardwired, so its busy bit can never be set.
    assign busy_d[0] = 1'b0;

    generate
        for (gi = 1; gi < NUM_REGS; gi++) begin : g_bit
            logic set_hit;
            logic clr_hit;
            assign set_hit    = set_valid_i && (set_addr_i == REG_ADDR_W'(gi));
            assign clr_hit    = clr_valid_i && (clr_addr_i == REG_ADDR_W'(gi));
            // A new issue to the same register outranks the retiring write.
            assign busy_d[gi] = set_hit | (busy_q[gi] & ~clr_hit);
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign op_addr[0] = rs1_addr_i;
    assign op_addr[1] = rs2_addr_i;
    assign op_addr[2] = rd_addr_i;

    // The registered write is not yet in the register file, so it also hazards.
    generate
        for (gi = 0; gi < 3; gi++) begin : g_op
            assign op_hit[gi] = (op_addr[gi] != '0) &&
                                (busy_q[op_addr[gi]] ||
                                 (wr_pending_i && (wr_addr_i == op_addr[gi])));
        end
    endgenerate

    assign busy_vec_o = busy_q;
    assign id_stall_o = |op_hit;

endmodule

// File: rtl/rf_write_scheduler.sv
// Merges pipeline WB and long-latency writebacks onto the single register-file
// write port, with starvation protection for the long-latency source.
module rf_write_scheduler
    import rf_write_scheduler_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wb_valid,
    input  logic [REG_ADDR_W-1:0] wb_rd_addr,
    input  logic [XLEN-1:0]       wb_rd_data,
    input  logic                  ll_valid,
    output logic                  ll_ready,
    input  logic [REG_ADDR_W-1:0] ll_rd_addr,
    input  logic [XLEN-1:0]       ll_rd_data,
    input  logic                  iss_ll_valid,
    input  logic [REG_ADDR_W-1:0] iss_rd_addr,
    input  logic [REG_ADDR_W-1:0] id_rs1_addr,
    input  logic [REG_ADDR_W-1:0] id_rs2_addr,
    input  logic [REG_ADDR_W-1:0] id_rd_addr,
    output logic                  id_stall,
    output logic                  pipe_hold,
    output logic                  rf_we,
    output logic [REG_ADDR_W-1:0] rf_waddr,
    output logic [XLEN-1:0]       rf_wdata,
    output logic [NUM_REGS-1:0]   busy_vec
);

    localparam int                CNT_W    = 4;
    localparam logic [CNT_W-1:0]  LIMIT_M1 = CNT_W'(STARVE_LIMIT - 1);

    state_e           state_q;
    state_e           state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    wr_req_t          out_q;
    wr_req_t          out_d;
    wr_req_t          wb_req;
    wr_req_t          ll_req;
    logic             ll_hs;
    logic             ll_blocked;

    assign wb_req = '{valid: wb_valid, addr: wb_rd_addr, data: wb_rd_data, src: SRC_WB};
    assign ll_req = '{valid: ll_valid, addr: ll_rd_addr, data: ll_rd_data, src: SRC_LL};

    // In GRANT the pipeline keeps wb_valid low, so this already grants LL there;
    // a WB that arrives in GRANT anyway wins and leaves the LL write pending.
    assign ll_ready   = !wb_valid;
    assign ll_hs      = ll_valid && ll_ready;
    assign ll_blocked = ll_valid && !ll_ready;

    always_comb begin
        out_d = '0;
        if (wb_valid) begin
            out_d = wb_req;
        end else if (ll_valid) begin
            out_d = ll_req;
        end
        // Writes to x0 are dropped here so they never reach the port or scoreboard.
        out_d.valid = out_d.valid && (out_d.addr != '0);
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        pipe_hold = 1'b0;
        unique case (state_q)
            NORMAL: begin
                if (ll_blocked) begin
                    if (cnt_q == LIMIT_M1) begin
                        state_d = HOLD;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end else begin
                    cnt_d = '0;
                end
            end
            HOLD: begin
                pipe_hold = 1'b1;
                cnt_d     = '0;
                state_d   = ll_hs ? NORMAL : GRANT;
            end
            GRANT: begin
                cnt_d   = '0;
                state_d = NORMAL;
            end
            default: begin
                cnt_d   = '0;
                state_d = NORMAL;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= NORMAL;
            cnt_q   <= '0;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            out_q   <= out_d;
        end
    end

    assign rf_we    = out_q.valid;
    assign rf_waddr = out_q.addr;
    assign rf_wdata = out_q.data;

    rf_scoreboard u_scoreboard (
        .clk          (clk),
        .rst_n        (rst),
        .set_valid_i  (iss_ll_valid),
        .set_addr_i   (iss_rd_addr),
        .clr_valid_i  (out_q.valid && (out_q.src == SRC_LL)),
        .clr_addr_i   (out_q.addr),
        .wr_pending_i (out_q.valid),
        .wr_addr_i    (out_q.addr),
        .rs1_addr_i   (id_rs1_addr),
        .rs2_addr_i   (id_rs2_addr),
        .rd_addr_i    (id_rd_addr),
        .busy_vec_o   (busy_vec),
        .id_stall_o   (id_stall)
    );

endmodule
